// File: rtl/multibyte_add_ctrl_pkg.sv
// Shared encodings for the multi-byte add/subtract sequencer.
// Holds the state encoding and the byte datapath width.
package multibyte_add_ctrl_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/multibyte_add_ctrl_adder.sv
// Shared 8-bit adder datapath: sum = a + b + cin,
// with the carry-out on a separate port.
module adder
   import multibyte_add_ctrl_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout
);

   logic [BYTE_W:0] w_full;

   assign w_full = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
   assign sum    = w_full[BYTE_W-1:0];
   assign cout   = w_full[BYTE_W];

endmodule

// File: rtl/multibyte_add_ctrl.sv
// Wide add/subtract built from one shared 8-bit adder,
// one byte per clock, LSB first, carry chained in a register.
module multibyte_add_ctrl
   import multibyte_add_ctrl_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     op_sub,
   input  logic [8*NBYTES-1:0]      a,
   input  logic [8*NBYTES-1:0]      b,
   output logic                     ready,
   output logic                     busy,
   output logic                     done,
   output logic [8*NBYTES-1:0]      result,
   output logic                     cout,
   output logic                     overflow
);

   localparam int IDXW = $clog2(NBYTES);
   localparam int MSB  = BYTE_W - 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDXW-1:0]       r_idx;
   logic [8*NBYTES-1:0]   r_opa;
   logic [8*NBYTES-1:0]   r_opb;
   logic [8*NBYTES-1:0]   r_result;
   logic                  r_carry;
   logic                  r_cout;
   logic                  r_ovf;
   logic                  r_done;

   logic                  w_ready;
   logic                  w_busy;
   logic                  w_accept;
   logic                  w_last;
   logic [BYTE_W-1:0]     w_a_byte;
   logic [BYTE_W-1:0]     w_b_byte;
   logic [BYTE_W-1:0]     w_sum;
   logic                  w_co;

   assign w_a_byte = r_opa[r_idx*BYTE_W +: BYTE_W];
   assign w_b_byte = r_opb[r_idx*BYTE_W +: BYTE_W];

   adder u_adder (
      .a    (w_a_byte),
      .b    (w_b_byte),
      .cin  (r_carry),
      .sum  (w_sum),
      .cout (w_co)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_busy      = 1'b0;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_ready = 1'b1;
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_busy = 1'b1;
            if (r_idx == LAST) begin
               w_last      = 1'b1;
               w_state_nxt = ST_FIN;
            end
         end
         ST_FIN:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Subtract is A + ~B + 1: B is inverted at latch, the +1 rides in on carry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx    <= '0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_opa    <= a;
            r_opb    <= op_sub ? ~b : b;
            r_carry  <= op_sub;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
         end
         if (r_state == ST_RUN) begin
            r_result[r_idx*BYTE_W +: BYTE_W] <= w_sum;
            r_carry <= w_co;
            if (w_last)
               r_ovf <= (w_a_byte[MSB] == w_b_byte[MSB]) &&
                        (w_sum[MSB] != w_a_byte[MSB]);
            else
               r_idx <= r_idx + 1'b1;
         end
         if (r_state == ST_FIN) begin
            r_done <= 1'b1;
            r_cout <= r_carry;
         end
      end
   end

   assign ready    = w_ready;
   assign busy     = w_busy;
   assign done     = r_done;
   assign result   = r_result;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// Directed and random checks of the multi-byte sequencer
// against a plain-arithmetic model of wide add/subtract.
module tb_multibyte_add_ctrl;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;

   int n_tests = 0;
   int n_fail  = 0;

   multibyte_add_ctrl #(.NBYTES(NB)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_sub   (op_sub),
      .a        (a),
      .b        (b),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic sub, input logic [W-1:0] x,
                        input logic [W-1:0] y, output logic [W-1:0] r,
                        output logic c, output logic v);
      logic [W:0] full;
      logic sx, sy, sr;
      if (sub) begin
         full = {1'b0, x} - {1'b0, y};
         c    = (x >= y);
      end else begin
         full = {1'b0, x} + {1'b0, y};
         c    = full[W];
      end
      r  = full[W-1:0];
      sx = x[W-1];
      sy = y[W-1];
      sr = r[W-1];
      v  = sub ? (sx != sy) && (sr != sx) : (sx == sy) && (sr != sx);
   endtask

   task automatic do_op(input string tag, input logic sub,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit spam);
      logic [W-1:0] er;
      logic ec, ev;
      int cyc;
      bit rdy_seen;
      model(sub, x, y, er, ec, ev);
      @(negedge clk);
      start  = 1'b1;
      op_sub = sub;
      a      = x;
      b      = y;
      @(posedge clk);
      #1;
      cyc      = 0;
      rdy_seen = 1'b0;
      while (!done && cyc < 20) begin
         if (ready) rdy_seen = 1'b1;
         if (spam) begin
            start  = 1'b1;
            op_sub = 1'($urandom);
            a      = $urandom;
            b      = $urandom;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_latency"}, 64'(cyc), 64'(NB + 1));
      chk({tag, "_ready_run"}, 64'(rdy_seen), 64'd0);
      chk({tag, "_result"}, 64'(result), 64'(er));
      chk({tag, "_cout"}, 64'(cout), 64'(ec));
      chk({tag, "_ovf"}, 64'(overflow), 64'(ev));
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
      chk({tag, "_hold"}, 64'(result), 64'(er));
   endtask

   initial begin
      logic [W-1:0] rx, ry;
      rst    = 1'b1;
      start  = 1'b1;
      op_sub = 1'b0;
      a      = '0;
      b      = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      start = 1'b0;
      rst   = 1'b0;

      do_op("add_ff_1", 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
      chk("dir_add_ff_1", 64'(result), 64'h0000_0100);
      do_op("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      chk("dir_add_wrap", 64'({cout, result}), 64'h1_0000_0000);
      do_op("sub_5_7", 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0);
      chk("dir_sub_5_7", 64'({cout, result}), 64'h0_FFFF_FFFE);
      do_op("sub_7_5", 1'b1, 32'h0000_0007, 32'h0000_0005, 1'b0);
      chk("dir_sub_7_5", 64'({cout, result}), 64'h1_0000_0002);
      do_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      chk("dir_add_ovf", 64'({overflow, result}), 64'h1_8000_0000);
      do_op("sub_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0);
      chk("dir_sub_ovf", 64'({overflow, result}), 64'h1_7FFF_FFFF);

      do_op("spam", 1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
      do_op("after_spam", 1'b1, 32'h0000_1000, 32'h0000_0001, 1'b0);

      @(negedge clk);
      start  = 1'b1;
      op_sub = 1'b0;
      a      = 32'h0101_0101;
      b      = 32'h0202_0202;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_ready", 64'(ready), 64'd1);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_result", 64'(result), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      begin
         bit saw_done = 1'b0;
         repeat (8) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
         end
         chk("abort_no_done", 64'(saw_done), 64'd0);
      end
      do_op("post_abort", 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0);

      for (int i = 0; i < 24; i++) begin
         rx = $urandom;
         ry = $urandom;
         if (i % 6 == 0) ry = rx;
         do_op($sformatf("rnd%0d", i), 1'($urandom), rx, ry, 1'(i % 3 == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
